// File: rtl/instr_pkg.sv
// Shared instruction-set definitions: field widths, opcodes, format helpers
// and the program-loader state encoding.
package instr_pkg;

  localparam int OP_W    = 4;
  localparam int REG_W   = 4;
  localparam int IMM_W   = 8;
  localparam int INSTR_W = 16;

  localparam logic [OP_W-1:0] OP_ADD  = 4'h0;
  localparam logic [OP_W-1:0] OP_SUB  = 4'h1;
  localparam logic [OP_W-1:0] OP_AND  = 4'h2;
  localparam logic [OP_W-1:0] OP_OR   = 4'h3;
  localparam logic [OP_W-1:0] OP_ADDI = 4'h4;
  localparam logic [OP_W-1:0] OP_LW   = 4'h5;
  localparam logic [OP_W-1:0] OP_SW   = 4'h6;
  localparam logic [OP_W-1:0] OP_BEQ  = 4'h7;
  localparam logic [OP_W-1:0] OP_XOR  = 4'h8;
  localparam logic [OP_W-1:0] OP_SLT  = 4'h9;
  localparam logic [OP_W-1:0] OP_LUI  = 4'hA;
  localparam logic [OP_W-1:0] OP_ANDI = 4'hB;
  localparam logic [OP_W-1:0] OP_JR   = 4'hC;
  localparam logic [OP_W-1:0] OP_J    = 4'hD;

  // One bit per opcode value; 4'hE and 4'hF have no encoding.
  localparam logic [15:0] ILLEGAL_OP = 16'hC000;

  typedef enum logic [1:0] {IDLE, LOAD, DRAIN, DONE} loader_state_t;

  function automatic logic is_itype(input logic [OP_W-1:0] op);
    logic r;
    case (op)
      OP_ADDI, OP_LW, OP_SW, OP_BEQ, OP_LUI, OP_ANDI, OP_J: r = 1'b1;
      default:                                              r = 1'b0;
    endcase
    return r;
  endfunction

  function automatic logic is_illegal(input logic [OP_W-1:0] op);
    return ILLEGAL_OP[op];
  endfunction

endpackage

// File: rtl/instr_fifo2.sv
// Two-entry synchronous FIFO; a simultaneous push and pop leave the level unchanged.
module instr_fifo2
  import instr_pkg::*;
#(
  parameter int W = INSTR_W
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         push_i,
  input  logic         pop_i,
  input  logic [W-1:0] wdata_i,
  output logic [W-1:0] rdata_o,
  output logic         full_o,
  output logic         empty_o,
  output logic [1:0]   level_o
);

  logic [W-1:0] mem_q [2];
  logic         wr_ptr_q, wr_ptr_d;
  logic         rd_ptr_q, rd_ptr_d;
  logic [1:0]   level_q, level_d;
  logic         do_push, do_pop;

  assign do_push = push_i && !full_o;
  assign do_pop  = pop_i && !empty_o;

  always_comb begin
    wr_ptr_d = wr_ptr_q ^ do_push;
    rd_ptr_d = rd_ptr_q ^ do_pop;
    level_d  = level_q + {1'b0, do_push} - {1'b0, do_pop};
  end

  // Storage is cleared on reset so the read port shows zero while empty.
  always_ff @(posedge clk) begin
    if (reset) begin
      mem_q[0] <= '0;
      mem_q[1] <= '0;
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      level_q  <= 2'd0;
    end else begin
      if (do_push) begin
        mem_q[wr_ptr_q] <= wdata_i;
      end
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
    end
  end

  assign rdata_o = mem_q[rd_ptr_q];
  assign full_o  = (level_q == 2'd2);
  assign empty_o = (level_q == 2'd0);
  assign level_o = level_q;

endmodule

// File: rtl/instr_encoder_loader.sv
// Encodes instruction fields into 16-bit words and streams them into imem
// at an auto-incrementing address during a start/finish load session.
module instr_encoder_loader
  import instr_pkg::*;
#(
  parameter int ADDR_W    = 6,
  parameter int BASE_ADDR = 0
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic               finish,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [OP_W-1:0]    in_op,
  input  logic [REG_W-1:0]   in_rd,
  input  logic [REG_W-1:0]   in_rs,
  input  logic [REG_W-1:0]   in_rt,
  input  logic [IMM_W-1:0]   in_imm,
  output logic               imem_we,
  output logic [ADDR_W-1:0]  imem_addr,
  output logic [INSTR_W-1:0] imem_wdata,
  output logic [ADDR_W:0]    count,
  output logic               busy,
  output logic               done,
  output logic               err
);

  localparam int                DEPTH   = 1 << ADDR_W;
  localparam logic [ADDR_W:0]   DEPTH_C = (ADDR_W+1)'(DEPTH);
  localparam logic [ADDR_W:0]   ONE_C   = (ADDR_W+1)'(1);
  localparam logic [ADDR_W-1:0] BASE_C  = ADDR_W'(BASE_ADDR);

  loader_state_t      state_q, state_d;
  logic [ADDR_W-1:0]  addr_q, addr_d;
  logic [ADDR_W:0]    count_q, count_d;
  logic               err_q, err_d;

  logic [INSTR_W-1:0] enc_word;
  logic [INSTR_W-1:0] buf_rdata;
  logic               buf_full, buf_empty;
  logic [1:0]         buf_level;
  logic               active, illegal, transfer, push, write;

  assign enc_word = is_itype(in_op) ? {in_op, in_rd, in_imm}
                                    : {in_op, in_rd, in_rs, in_rt};
  assign illegal  = is_illegal(in_op);
  assign active   = (state_q == LOAD) || (state_q == DRAIN);

  // Buffered words count against capacity so a session never overruns imem.
  assign in_ready = (state_q == LOAD) && !buf_full &&
                    ((count_q + (ADDR_W+1)'(buf_level)) < DEPTH_C);
  assign transfer = in_valid && in_ready;
  assign push     = transfer && !illegal;
  assign write    = active && !buf_empty;

  instr_fifo2 #(.W(INSTR_W)) u_fifo (
    .clk     (clk),
    .reset   (reset),
    .push_i  (push),
    .pop_i   (write),
    .wdata_i (enc_word),
    .rdata_o (buf_rdata),
    .full_o  (buf_full),
    .empty_o (buf_empty),
    .level_o (buf_level)
  );

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    count_d = count_q;
    err_d   = err_q;
    case (state_q)
      IDLE, DONE: begin
        if (start) begin
          state_d = LOAD;
          addr_d  = BASE_C;
          count_d = '0;
          err_d   = 1'b0;
        end
      end
      LOAD: begin
        if (write && ((count_q + ONE_C) == DEPTH_C)) begin
          state_d = DONE;
        end else if (finish) begin
          state_d = DRAIN;
        end
      end
      DRAIN: begin
        if (buf_empty) begin
          state_d = DONE;
        end
      end
      default: state_d = IDLE;
    endcase
    if (write) begin
      addr_d  = addr_q + ADDR_W'(1);
      count_d = count_q + ONE_C;
    end
    if (transfer && illegal) begin
      err_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      addr_q  <= BASE_C;
      count_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      count_q <= count_d;
      err_q   <= err_d;
    end
  end

  assign imem_we    = write;
  assign imem_addr  = addr_q;
  assign imem_wdata = buf_rdata;
  assign count      = count_q;
  assign busy       = active;
  assign done       = (state_q == DONE);
  assign err        = err_q;

endmodule

// File: doc/instr_encoder_loader.md
Name: instr_encoder_loader

Overview:
Inverse of the main decoder path. Accepts instruction fields over a valid/ready handshake and encodes them into 16-bit instruction words. Streams the words into instruction memory through a write port with an auto-incrementing address, so programs can be loaded before the CPU core leaves reset. Sits between the bench/boot source and imem, upstream of the fetch path that feeds the main decoder.

Parameters:
ADDR_W, 6, imem address width; capacity DEPTH = 2**ADDR_W words
BASE_ADDR, 0, first imem address written after start

Ports:
clk  in  1  system clock, rising edge
reset  in  1  synchronous, active-high reset
start  in  1  one-cycle pulse; begins a load session at BASE_ADDR
finish  in  1  one-cycle pulse; ends the session once the buffer drains
in_valid  in  1  instruction fields valid
in_ready  out  1  encoder can accept fields this cycle
in_op  in  4  opcode
in_rd  in  4  destination register
in_rs  in  4  source register 1
in_rt  in  4  source register 2 (R-type only)
in_imm  in  8  immediate (I-type only)
imem_we  out  1  imem write strobe
imem_addr  out  ADDR_W  imem write address
imem_wdata  out  16  encoded instruction word
count  out  ADDR_W+1  words written this session
busy  out  1  session active (LOAD or DRAIN)
done  out  1  session complete; held until next start or reset
err  out  1  sticky illegal-opcode flag; cleared by start or reset

Behaviour:
- Reset values:
  - in_ready=0, imem_we=0, imem_addr=BASE_ADDR, imem_wdata=0, count=0, busy=0, done=0, err=0.
  - State is IDLE and the buffer is emptied.
- Encoding (combinational on acceptance, registered into the buffer):
  - R-type: {op, rd, rs, rt}.
  - I-type: {op, rd, imm[7:0]}.
  - Format is selected by the package function is_itype(op).
- Illegal opcodes are 4'hE and 4'hF.
  - The handshake still completes (in_ready honoured).
  - The word is dropped and err is set. It is not counted.
- Handshake:
  - Transfer occurs when in_valid && in_ready.
  - in_ready = (state==LOAD) && buffer not full && (count + buffered words < DEPTH).
  - Fields are sampled only on a transfer.
- Buffer is 2 entries deep, giving full throughput with registered output:
  - One accepted word per cycle.
  - One imem write per cycle whenever the buffer is non-empty and state is LOAD or DRAIN.
- Latency: a word accepted at edge N is presented with imem_we=1 in the cycle after edge N (visible until edge N+1) when the buffer was empty.
- Each write:
  - imem_addr is the current address.
  - After the write, address increments by 1 (modulo 2**ADDR_W) and count increments by 1.
- States:
  - IDLE: start → LOAD (clear count and err, address=BASE_ADDR, done=0).
  - LOAD:
    - finish → DRAIN.
    - count reaching DEPTH after a write → DONE. in_ready is already 0 because of the DEPTH guard.
  - DRAIN: in_ready=0; buffer empty → DONE.
  - DONE: done=1, busy=0, in_ready=0; start → LOAD (new session).
- Simultaneous events:
  - start in LOAD or DRAIN is ignored.
  - finish outside LOAD is ignored.
  - finish in the same cycle as a transfer: the transfer is accepted, then the session drains.
  - A transfer in the same cycle as a write: both occur and the buffer occupancy is unchanged.
- Wrap-around: with BASE_ADDR ≠ 0, the address wraps past DEPTH-1 to 0. The session still ends after DEPTH words.
- Reset mid-session: immediately returns to the reset values above. Buffered words are discarded and never written.

Decomposition:
- Shared package instr_pkg:
  - Opcode localparams (OP_ADD … OP_J).
  - ILLEGAL_OP set.
  - Function is_itype.
  - Field widths (OP_W=4, REG_W=4, IMM_W=8, INSTR_W=16).
  - Enum loader_state_t {IDLE, LOAD, DRAIN, DONE}.
- The package is shared with the main decoder and its benches.
- Sub-module: instr_fifo2, a 2-entry synchronous FIFO with push/pop/full/empty, 16-bit data, same clk/reset.

Test Plan:
- Reset, then start, then one R-type (op=0, rd=1, rs=2, rt=3) → one cycle later imem_we=1, addr=0, wdata=16'h0123; count=1.
- Back-to-back: 4 I-type words with op=4, imm=8'hA5 and in_valid held → in_ready stays 1 and writes land on consecutive cycles at addr 0..3. finish → DONE within 2 cycles, done=1.
- Fill with ADDR_W=2: feed 6 words → exactly 4 accepted, in_ready=0 after the 4th. Auto-DONE, count=4, no 5th write.
- Illegal op 4'hF between two legal words → handshake completes and err=1. Only 2 writes at addr 0,1, count=2. The next start clears err.
- BASE_ADDR=62, ADDR_W=6: 3 words → addresses 62, 63, 0.
- Reset asserted with 2 words buffered → no further imem_we; all outputs at reset values on the next cycle. start/finish pulses in IDLE/DONE behave per the state rules.
